// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack sequencer and its stack-pointer partner (sp_mod).
//   sp_sel_e : command to sp_mod (hold / inc / dec / bus loads that this block never issues)
//   op_e     : operation requested with start
//   state_e  : sequencer states
package stack_seq_pkg;

  typedef enum logic [2:0] {
    SpHold       = 3'd0,
    SpIncr       = 3'd1,
    SpDecr       = 3'd2,
    SpDataBus    = 3'd3,
    SpDataBusRel = 3'd4
  } sp_sel_e;

  typedef enum logic {
    OpPush = 1'b0,
    OpPop  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPushDec = 3'd1,
    StPushHi  = 3'd2,
    StPushLo  = 3'd3,
    StPopLo   = 3'd4,
    StPopHi   = 3'd5
  } state_e;

endpackage

// File: rtl/stack_seq.sv
// Stack sequencer: moves a 16-bit word to/from a byte-wide memory using an external
// stack pointer (sp_mod). PUSH pre-decrements twice, writing the high byte then the low
// byte; POP reads the low byte then the high byte, post-incrementing twice.
// Ports:
//   clock, reset (async, active-low)
//   start, op, push_data  : request, sampled only in IDLE
//   sp                    : current stack pointer from sp_mod
//   mem_data              : combinational memory read data
//   sp_sel                : command to sp_mod (0 hold, 1 inc, 2 dec)
//   addr_bus, data_out    : memory address / write data
//   mem_wr, mem_rd        : one-cycle-per-byte strobes
//   pop_data              : last popped word
//   busy, done            : busy in every non-IDLE state; done pulses in first IDLE cycle
module stack_seq
  import stack_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] push_data,
  input  logic [15:0] sp,
  input  logic [7:0]  mem_data,
  output logic [2:0]  sp_sel,
  output logic [15:0] addr_bus,
  output logic [7:0]  data_out,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [15:0] pop_data,
  output logic        busy,
  output logic        done
);

  state_e      state;
  sp_sel_e     sp_cmd;
  logic        addr_en;
  logic [15:0] push_q;

  assign sp_sel = sp_cmd;
  // sp only settles one edge after the command, so the address is passed through live
  // rather than registered; addr_en marks the memory-access states.
  assign addr_bus = addr_en ? sp : 16'h0000;

  // Outputs are registered alongside the state: each branch loads the values that belong
  // to the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      sp_cmd   <= SpHold;
      addr_en  <= 1'b0;
      data_out <= 8'h00;
      mem_wr   <= 1'b0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      push_q   <= 16'h0000;
      pop_data <= 16'h0000;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            push_q <= push_data;
            busy   <= 1'b1;
            if (op_e'(op) == OpPop) begin
              state   <= StPopLo;
              sp_cmd  <= SpIncr;
              addr_en <= 1'b1;
              mem_rd  <= 1'b1;
            end else begin
              state  <= StPushDec;
              sp_cmd <= SpDecr;
            end
          end
        end
        StPushDec: begin
          state    <= StPushHi;
          sp_cmd   <= SpDecr;
          addr_en  <= 1'b1;
          mem_wr   <= 1'b1;
          data_out <= push_q[15:8];
        end
        StPushHi: begin
          state    <= StPushLo;
          sp_cmd   <= SpHold;
          data_out <= push_q[7:0];
        end
        StPushLo: begin
          state    <= StIdle;
          addr_en  <= 1'b0;
          mem_wr   <= 1'b0;
          data_out <= 8'h00;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        StPopLo: begin
          state          <= StPopHi;
          pop_data[7:0]  <= mem_data;
        end
        StPopHi: begin
          state          <= StIdle;
          pop_data[15:8] <= mem_data;
          sp_cmd         <= SpHold;
          addr_en        <= 1'b0;
          mem_rd         <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b1;
        end
        default: begin
          state    <= StIdle;
          sp_cmd   <= SpHold;
          addr_en  <= 1'b0;
          data_out <= 8'h00;
          mem_wr   <= 1'b0;
          mem_rd   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
